// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Serial program loader. Receives 8N1 UART bytes on RXD. The first four
//   bytes form a little-endian length header. The payload that follows is
//   packed into 32-bit words, which are written to dmem, and into 128-bit
//   lines, which are written to imem. DONE rises when the whole image has
//   been written.
//
//   Optional build macro: PLOADER_CHKSUM_EN
//     When defined, one extra byte follows the payload. It must equal the
//     modulo-256 sum of the payload bytes. A mismatch raises ERR and parks
//     the loader until reset.
//
// Ports
//   clk      in   system clock
//   reset_x  in   asynchronous active-low reset
//   RXD      in   UART serial input, idle high
//   ADDR     out  byte address of the most recently written word
//   DATA     out  last four words, newest in [127:96]
//   WE_32    out  one-cycle dmem word write strobe
//   WE_128   out  one-cycle imem line write strobe (with the line's 4th WE_32)
//   DONE     out  load complete, sticky
//   ERR      out  framing/checksum error seen, sticky
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low level
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sample 8 data bits, LSB first
//   RX_STOP  | sample the stop bit, emit byte_vld or flag a framing error
//
// Loader FSM
//   state    | meaning
//   LD_HDR   | collecting the 4 length bytes
//   LD_LOAD  | packing payload bytes, issuing write strobes
//   LD_FIN   | load finished, DONE held high
//   LD_CHK   | waiting for the checksum byte (checksum build only)
//   LD_HALT  | checksum mismatch, parked until reset (checksum build only)

module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_LEN     = 32,
    parameter int LEN_BITS     = 24
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                RXD,
    output logic [ADDR_LEN-1:0] ADDR,
    output logic [127:0]        DATA,
    output logic                WE_32,
    output logic                WE_128,
    output logic                DONE,
    output logic                ERR
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] LD_HDR  = 3'd0;
    localparam logic [2:0] LD_LOAD = 3'd1;
    localparam logic [2:0] LD_FIN  = 3'd2;
`ifdef PLOADER_CHKSUM_EN
    localparam logic [2:0] LD_CHK  = 3'd3;
    localparam logic [2:0] LD_HALT = 3'd4;
    localparam logic [2:0] LD_END  = LD_CHK;
`else
    localparam logic [2:0] LD_END  = LD_FIN;
`endif

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic          rxd_s1;
    logic          rxd_s2;
    logic [1:0]    rx_state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_sr;
    logic          byte_vld;
    logic          timer_zero;
    logic          frame_err;

    assign timer_zero = (timer == '0);
    assign frame_err  = (rx_state == RX_STOP) && timer_zero && !rxd_s2;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rx_state <= RX_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            byte_vld <= 1'b0;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            byte_vld <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_s2) begin
                        rx_state <= RX_START;
                        timer    <= TW'(CLKS_PER_BIT / 2 - 1);
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (!timer_zero) begin
                        timer <= timer - 1'b1;
                    end else if (rxd_s2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        timer    <= TW'(CLKS_PER_BIT - 1);
                    end
                end
                RX_DATA: begin
                    if (!timer_zero) begin
                        timer <= timer - 1'b1;
                    end else begin
                        rx_sr   <= {rxd_s2, rx_sr[7:1]};
                        timer   <= TW'(CLKS_PER_BIT - 1);
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end
                end
                default: begin
                    if (!timer_zero) begin
                        timer <= timer - 1'b1;
                    end else begin
                        // Back to IDLE at once so a start bit right after
                        // the stop bit is not missed.
                        rx_state <= RX_IDLE;
                        byte_vld <= rxd_s2;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    logic [2:0]          ld_state;
    logic [1:0]          hdr_cnt;
    logic [23:0]         hdr_sr;
    logic [23:0]         word_sr;
    logic [LEN_BITS-1:0] eff_len;
    logic [LEN_BITS-1:0] byte_cnt;
    logic [LEN_BITS-1:0] hdr_len;
    logic                chk_fail;

    // Header bytes arrive LSB first; only the low LEN_BITS count and the
    // length is rounded down to whole words.
    assign hdr_len = LEN_BITS'({rx_sr, hdr_sr}) & ~LEN_BITS'(3);

`ifdef PLOADER_CHKSUM_EN
    logic [7:0] sum;
    assign chk_fail = (ld_state == LD_CHK) && byte_vld && (rx_sr != sum);
`else
    assign chk_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            ld_state <= LD_HDR;
            hdr_cnt  <= '0;
            hdr_sr   <= '0;
            word_sr  <= '0;
            eff_len  <= '0;
            byte_cnt <= '0;
            ADDR     <= '0;
            DATA     <= '0;
            WE_32    <= 1'b0;
            WE_128   <= 1'b0;
            DONE     <= 1'b0;
`ifdef PLOADER_CHKSUM_EN
            sum      <= '0;
`endif
        end else begin
            WE_32  <= 1'b0;
            WE_128 <= 1'b0;
            case (ld_state)
                LD_HDR: begin
                    if (byte_vld) begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                        hdr_sr  <= {rx_sr, hdr_sr[23:8]};
                        if (hdr_cnt == 2'd3) begin
                            eff_len  <= hdr_len;
                            byte_cnt <= '0;
                            ld_state <= (hdr_len == '0) ? LD_END : LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    if (byte_vld) begin
                        word_sr  <= {rx_sr, word_sr[23:8]};
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef PLOADER_CHKSUM_EN
                        sum      <= sum + rx_sr;
`endif
                        if (byte_cnt[1:0] == 2'd3) begin
                            DATA   <= {rx_sr, word_sr, DATA[127:32]};
                            ADDR   <= ADDR_LEN'(byte_cnt & ~LEN_BITS'(3));
                            WE_32  <= 1'b1;
                            WE_128 <= (byte_cnt[3:0] == 4'hF);
                        end
                        // eff_len is a word multiple, so the last byte always
                        // completes a word.
                        if (byte_cnt == eff_len - LEN_BITS'(1)) begin
                            ld_state <= LD_END;
                        end
                    end
                end
`ifdef PLOADER_CHKSUM_EN
                LD_CHK: begin
                    if (byte_vld) begin
                        if (rx_sr == sum) begin
                            DONE     <= 1'b1;
                            ld_state <= LD_FIN;
                        end else begin
                            ld_state <= LD_HALT;
                        end
                    end
                end
                LD_HALT: begin
                    ld_state <= LD_HALT;
                end
`endif
                LD_FIN: begin
                    DONE <= 1'b1;
                end
                default: begin
                    ld_state <= LD_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            ERR <= 1'b0;
        end else if (frame_err || chk_fail) begin
            ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    localparam int CPB = 16;

    logic         clk;
    logic         reset_x;
    logic         RXD;
    logic [31:0]  ADDR;
    logic [127:0] DATA;
    logic         WE_32;
    logic         WE_128;
    logic         DONE;
    logic         ERR;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_LEN(32), .LEN_BITS(24)) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .RXD     (RXD),
        .ADDR    (ADDR),
        .DATA    (DATA),
        .WE_32   (WE_32),
        .WE_128  (WE_128),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // strobe log, sampled on the falling edge
    int           cyc = 0;
    int           last_we_cyc = 0;
    int           done_cyc = 0;
    bit           done_seen = 0;
    int           w128_cnt = 0;
    logic [31:0]  log_addr[$];
    logic [127:0] log_data[$];
    bit           log_w128[$];

    always @(negedge clk) begin
        cyc++;
        if (WE_32) begin
            log_addr.push_back(ADDR);
            log_data.push_back(DATA);
            log_w128.push_back(WE_128);
            last_we_cyc = cyc;
        end
        if (WE_128) w128_cnt++;
        if (DONE && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_w128.delete();
        w128_cnt  = 0;
        done_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_x = 1'b0;
        RXD     = 1'b1;
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RXD = stop;
        repeat (CPB) @(negedge clk);
        RXD = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] pl[$];

    task automatic send_load(input logic [31:0] len);
`ifdef PLOADER_CHKSUM_EN
        logic [7:0] s = 8'h00;
`endif
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
        foreach (pl[i]) begin
            send_byte(pl[i], 1'b1);
`ifdef PLOADER_CHKSUM_EN
            s = s + pl[i];
`endif
        end
`ifdef PLOADER_CHKSUM_EN
        send_byte(s, 1'b1);
`endif
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && !DONE; i++) @(negedge clk);
        check_val({tag, "_done"}, DONE, 1'b1);
    endtask

    task automatic check_done_lat(input string tag);
`ifndef PLOADER_CHKSUM_EN
        check_val({tag, "_done_lat"}, done_cyc - last_we_cyc, 1);
`else
        check_val({tag, "_done_seen"}, done_seen, 1'b1);
`endif
    endtask

    initial begin
        reset_x = 1'b0;
        RXD     = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_addr", ADDR, 0);
        check_val("rst_data", DATA, 0);
        check_val("rst_we32", WE_32, 0);
        check_val("rst_we128", WE_128, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_err", ERR, 0);
        reset_x = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();

        // A: single word
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_load(32'h0000_0004);
        wait_done("a");
        check_val("a_nwe", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check_val("a_addr", log_addr[0], 32'h0);
            check_val("a_word", log_data[0][127:96], 32'h0000_0013);
        end
        check_val("a_nw128", w128_cnt, 0);
        check_done_lat("a");
        check_val("a_err", ERR, 0);

        // reset in the middle of a frame clears everything at once
        RXD = 1'b0;
        repeat (40) @(negedge clk);
        #2 reset_x = 1'b0;
        #1;
        check_val("mid_done", DONE, 0);
        check_val("mid_data", DATA, 0);
        check_val("mid_addr", ADDR, 0);
        check_val("mid_we32", WE_32, 0);
        RXD = 1'b1;
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_load(32'h0000_0004);
        wait_done("mid");
        check_val("mid_nwe", log_addr.size(), 1);
        if (log_addr.size() == 1)
            check_val("mid_word", log_data[0][127:96], 32'h4433_2211);

        // B: one full line
        do_reset();
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'(i));
        send_load(32'h0000_0010);
        wait_done("b");
        check_val("b_nwe", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check_val("b_addr0", log_addr[0], 32'h0);
            check_val("b_addr1", log_addr[1], 32'h4);
            check_val("b_addr2", log_addr[2], 32'h8);
            check_val("b_addr3", log_addr[3], 32'hC);
            check_val("b_w128_early", {log_w128[0], log_w128[1], log_w128[2]}, 3'b000);
            check_val("b_w128_last", log_w128[3], 1'b1);
            check_val("b_line", log_data[3], 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        end
        check_val("b_nw128", w128_cnt, 1);
        check_done_lat("b");

        // C: 20 bytes, one line plus a partial line
        do_reset();
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(i));
        send_load(32'h0000_0014);
        wait_done("c");
        check_val("c_nwe", log_addr.size(), 5);
        if (log_addr.size() == 5) begin
            check_val("c_addr4", log_addr[4], 32'h10);
            check_val("c_w128_last", log_w128[4], 1'b0);
            check_val("c_data4", log_data[4], 128'h13121110_0F0E0D0C_0B0A0908_07060504);
        end
        check_val("c_nw128", w128_cnt, 1);
        check_done_lat("c");

        // D: zero length; high header byte and low two bits are ignored
        do_reset();
        pl.delete();
        send_load(32'hFF00_0003);
        wait_done("d");
        check_val("d_nwe", log_addr.size(), 0);
        check_val("d_nw128", w128_cnt, 0);

        // E: framing error and start glitch are both dropped
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00, 1'b1);
        send_byte(8'h55, 1'b0);
        check_val("e_err", ERR, 1'b1);
        // low pulse that is gone again by the half-bit resample
        RXD = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        RXD = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_val("e_glitch_nwe", log_addr.size(), 0);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        send_byte(8'hA4, 1'b1);
`ifdef PLOADER_CHKSUM_EN
        send_byte(8'h8A, 1'b1);
`endif
        wait_done("e");
        check_val("e_nwe", log_addr.size(), 1);
        if (log_addr.size() == 1)
            check_val("e_word", log_data[0][127:96], 32'hA4A3_A2A1);
        check_val("e_err_sticky", ERR, 1'b1);

`ifdef PLOADER_CHKSUM_EN
        // checksum match
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        check_val("k_done_pre", DONE, 1'b0);
        send_byte(8'h0A, 1'b1);
        wait_done("k");
        check_val("k_err", ERR, 1'b0);

        // checksum mismatch parks the loader
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h0B, 1'b1);
        check_val("kb_err", ERR, 1'b1);
        check_val("kb_done", DONE, 1'b0);
        send_byte(8'h0A, 1'b1);
        repeat (200) @(negedge clk);
        check_val("kb_done_late", DONE, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
